exu_ctrl: RTL and testbench

EXU_CTRL -- requirements
Module: exu_ctrl

---
 rtl/exu_ctrl.sv | 86 ++++++++
 tb/tb_exu_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/exu_ctrl.sv
// exu_ctrl: execute-stage controller holding one instruction, sequencing ALU/MDU results to LSU and raising fetch redirects.
module exu_ctrl #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  input  logic [XLEN-1:0] in_imm,
  input  logic [4:0]      in_rd,
  input  logic            in_wen,
  input  logic            in_is_mdu,
  input  logic            in_is_branch,
  input  logic            in_is_jal,
  input  logic            in_is_jalr,
  output logic [XLEN-1:0] ex_pc_o,
  output logic [XLEN-1:0] ex_src1_o,
  output logic [XLEN-1:0] ex_src2_o,
  output logic [XLEN-1:0] ex_imm_o,
  input  logic [XLEN-1:0] alu_res_i,
  input  logic            alu_cnd_i,
  output logic            mdu_req_o,
  output logic            mdu_kill_o,
  input  logic            mdu_done_i,
  input  logic [XLEN-1:0] mdu_res_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_res,
  output logic [4:0]      out_rd,
  output logic            out_wen,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  input  logic            flush_i
);
  typedef enum logic [1:0] {IDLE, EXEC, MDU_WAIT, OUT} state_t;
  state_t state_q, state_d;
  logic [XLEN-1:0] pc_q, src1_q, src2_q, imm_q, res_q, res_d, redir_pc_q, redir_pc_d, jalr_sum;
  logic [4:0] rd_q;
  logic wen_q, mdu_q, br_q, jal_q, jalr_q, redir_v_q, redir_v_d, accept;
  assign in_ready = rst_n & ~flush_i & ((state_q == IDLE) | ((state_q == OUT) & out_ready));
  assign accept = in_valid & in_ready;
  assign jalr_sum = src1_q + imm_q;
  assign ex_pc_o = pc_q;
  assign ex_src1_o = src1_q;
  assign ex_src2_o = src2_q;
  assign ex_imm_o = imm_q;
  assign out_valid = state_q == OUT;
  assign out_res = res_q;
  assign out_rd = rd_q;
  assign out_wen = wen_q;
  assign mdu_req_o = state_q == MDU_WAIT;
  assign mdu_kill_o = rst_n & flush_i & (state_q == MDU_WAIT);
  assign redirect_valid_o = redir_v_q;
  assign redirect_pc_o = redir_pc_q;
  always_comb begin
    state_d = flush_i ? IDLE :
              (state_q == IDLE)     ? (accept ? EXEC : IDLE) :
              (state_q == EXEC)     ? (mdu_q ? MDU_WAIT : OUT) :
              (state_q == MDU_WAIT) ? (mdu_done_i ? OUT : MDU_WAIT) :
              out_ready ? (in_valid ? EXEC : IDLE) : OUT;
    res_d = ((state_q == EXEC) & ~mdu_q) ? alu_res_i :
            ((state_q == MDU_WAIT) & mdu_done_i) ? mdu_res_i : res_q;
    redir_v_d = ~flush_i & (state_q == EXEC) & (jal_q | jalr_q | (br_q & alu_cnd_i));
    // jalr clears bit 0 of the target; jal/branch use pc-relative
    redir_pc_d = ~redir_v_d ? redir_pc_q : jalr_q ? {jalr_sum[XLEN-1:1], 1'b0} : pc_q + imm_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      {pc_q, src1_q, src2_q, imm_q, res_q, redir_pc_q} <= '0;
      {rd_q, wen_q, mdu_q, br_q, jal_q, jalr_q, redir_v_q} <= '0;
    end else begin
      state_q <= state_d;
      res_q <= res_d;
      redir_v_q <= redir_v_d;
      redir_pc_q <= redir_pc_d;
      if (accept) begin
        {pc_q, src1_q, src2_q, imm_q} <= {in_pc, in_src1, in_src2, in_imm};
        {rd_q, wen_q, mdu_q, br_q, jal_q, jalr_q} <= {in_rd, in_wen, in_is_mdu, in_is_branch, in_is_jal, in_is_jalr};
      end
    end
  end
endmodule

// File: tb/tb_exu_ctrl.sv
// tb_exu_ctrl: directed scenario tests for exu_ctrl with hand-computed expectations.
module tb_exu_ctrl;
  localparam int XLEN = 64;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_ready;
  logic [XLEN-1:0] in_pc = 0, in_src1 = 0, in_src2 = 0, in_imm = 0;
  logic [4:0] in_rd = 0;
  logic in_wen = 0, in_is_mdu = 0, in_is_branch = 0, in_is_jal = 0, in_is_jalr = 0;
  logic [XLEN-1:0] ex_pc_o, ex_src1_o, ex_src2_o, ex_imm_o;
  logic [XLEN-1:0] alu_res_i = 0, mdu_res_i = 0;
  logic alu_cnd_i = 0, mdu_req_o, mdu_kill_o, mdu_done_i = 0;
  logic out_valid, out_ready = 1, out_wen, redirect_valid_o, flush_i = 0;
  logic [XLEN-1:0] out_res, redirect_pc_o;
  logic [4:0] out_rd;
  int n_vec = 0, n_err = 0;

  exu_ctrl #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_src1(in_src1), .in_src2(in_src2), .in_imm(in_imm),
    .in_rd(in_rd), .in_wen(in_wen), .in_is_mdu(in_is_mdu), .in_is_branch(in_is_branch),
    .in_is_jal(in_is_jal), .in_is_jalr(in_is_jalr),
    .ex_pc_o(ex_pc_o), .ex_src1_o(ex_src1_o), .ex_src2_o(ex_src2_o), .ex_imm_o(ex_imm_o),
    .alu_res_i(alu_res_i), .alu_cnd_i(alu_cnd_i), .mdu_req_o(mdu_req_o), .mdu_kill_o(mdu_kill_o),
    .mdu_done_i(mdu_done_i), .mdu_res_i(mdu_res_i), .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_rd(out_rd), .out_wen(out_wen),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o), .flush_i(flush_i)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    @(negedge clk);
  endtask

  task automatic drive_op(input logic [XLEN-1:0] pc, s1, imm, input logic [4:0] rd,
                          input logic mdu, br, jal, jalr);
    in_valid = 1; in_pc = pc; in_src1 = s1; in_src2 = ~s1; in_imm = imm; in_rd = rd; in_wen = 1;
    in_is_mdu = mdu; in_is_branch = br; in_is_jal = jal; in_is_jalr = jalr;
  endtask

  task automatic test_reset;
    rst_n = 0;
    drive_op(64'h1234, 64'h55, 64'h8, 5'd4, 0, 0, 1, 0);
    step; step; mid;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    n_vec++; if ({out_valid, redirect_valid_o, mdu_req_o, mdu_kill_o} !== 4'b0) begin n_err++;
      $display("FAIL reset_ctrl got %b want 0000", {out_valid, redirect_valid_o, mdu_req_o, mdu_kill_o}); end
    n_vec++; if ({ex_pc_o, out_res, out_rd, out_wen, redirect_pc_o} !== '0) begin n_err++;
      $display("FAIL reset_data got pc=%h res=%h rd=%0d", ex_pc_o, out_res, out_rd); end
    step; in_valid = 0; rst_n = 1;
  endtask

  task automatic test_alu;
    step; drive_op(64'h100, 64'd5, 64'd0, 5'd3, 0, 0, 0, 0); mid;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL alu_accept got %b want 1", in_ready); end
    step; in_valid = 0; alu_res_i = 64'd12; mid;
    n_vec++; if ({out_valid, ex_src1_o, ex_src2_o} !== {1'b0, 64'd5, ~64'd5}) begin n_err++;
      $display("FAIL alu_exec got v=%b s1=%h s2=%h want v=0 s1=5", out_valid, ex_src1_o, ex_src2_o); end
    step; alu_res_i = 64'd99; mid;
    n_vec++; if ({out_valid, out_res, out_rd, out_wen} !== {1'b1, 64'd12, 5'd3, 1'b1}) begin n_err++;
      $display("FAIL alu_out got v=%b res=%0d rd=%0d wen=%b want 1/12/3/1", out_valid, out_res, out_rd, out_wen); end
    step; mid;
    n_vec++; if ({out_valid, in_ready} !== 2'b01) begin n_err++;
      $display("FAIL alu_idle got v=%b rdy=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_mdu;
    int req_cnt = 0;
    step; drive_op(64'h200, 64'd6, 64'd0, 5'd8, 1, 0, 0, 0);
    step; in_valid = 0; mdu_done_i = 1; mdu_res_i = 64'h1111; mid;
    n_vec++; if (mdu_req_o !== 1'b0) begin n_err++; $display("FAIL mdu_exec_req got %b want 0", mdu_req_o); end
    for (int i = 0; i < 7; i++) begin
      step; mdu_done_i = (i == 6); mdu_res_i = 64'hDEAD; mid;
      if (mdu_req_o === 1'b1) req_cnt++;
    end
    step; mdu_done_i = 0; mid;
    n_vec++; if (req_cnt !== 7) begin n_err++; $display("FAIL mdu_req_cycles got %0d want 7", req_cnt); end
    n_vec++; if ({out_valid, mdu_req_o, out_res} !== {2'b10, 64'hDEAD}) begin n_err++;
      $display("FAIL mdu_out got v=%b req=%b res=%h want 1/0/dead", out_valid, mdu_req_o, out_res); end
    step;
  endtask

  task automatic test_redirect;
    step; drive_op(64'h1000, 64'h8000_0003, 64'd4, 5'd1, 0, 0, 0, 1);
    step; in_valid = 0; mid;
    n_vec++; if (redirect_valid_o !== 1'b0) begin n_err++; $display("FAIL jalr_early got %b want 0", redirect_valid_o); end
    step; mid;
    n_vec++; if ({redirect_valid_o, redirect_pc_o} !== {1'b1, 64'h8000_0006}) begin n_err++;
      $display("FAIL jalr_target got v=%b pc=%h want 1/80000006", redirect_valid_o, redirect_pc_o); end
    step; mid;
    n_vec++; if (redirect_valid_o !== 1'b0) begin n_err++; $display("FAIL jalr_pulse got %b want 0", redirect_valid_o); end
    drive_op(64'h2000, 64'd0, 64'h10, 5'd0, 0, 1, 0, 0);
    step; in_valid = 0; alu_cnd_i = 0;
    step; mid;
    n_vec++; if (redirect_valid_o !== 1'b0) begin n_err++; $display("FAIL br_not_taken got %b want 0", redirect_valid_o); end
    step; drive_op(64'h2000, 64'd0, 64'h10, 5'd0, 0, 1, 0, 0);
    step; in_valid = 0; alu_cnd_i = 1;
    step; alu_cnd_i = 0; mid;
    n_vec++; if ({redirect_valid_o, redirect_pc_o} !== {1'b1, 64'h2010}) begin n_err++;
      $display("FAIL br_taken got v=%b pc=%h want 1/2010", redirect_valid_o, redirect_pc_o); end
    step;
  endtask

  task automatic test_back_to_back;
    int held_bad = 0;
    out_ready = 0;
    step; drive_op(64'h300, 64'h11, 64'd0, 5'd7, 0, 0, 0, 0);
    step; in_valid = 0; alu_res_i = 64'h55;
    step; drive_op(64'h400, 64'h77, 64'd0, 5'd9, 0, 0, 0, 0); alu_res_i = 64'h0;
    for (int i = 0; i < 5; i++) begin
      mid;
      if ({out_valid, in_ready, out_res, out_rd, ex_src1_o} !== {2'b10, 64'h55, 5'd7, 64'h11}) held_bad++;
      step;
    end
    n_vec++; if (held_bad !== 0) begin n_err++; $display("FAIL stall_hold got %0d bad cycles want 0", held_bad); end
    out_ready = 1; mid;
    n_vec++; if ({in_ready, out_valid} !== 2'b11) begin n_err++;
      $display("FAIL b2b_accept got rdy=%b v=%b want 1/1", in_ready, out_valid); end
    step; in_valid = 0; alu_res_i = 64'h66; mid;
    n_vec++; if ({out_valid, ex_src1_o} !== {1'b0, 64'h77}) begin n_err++;
      $display("FAIL b2b_exec got v=%b s1=%h want 0/77", out_valid, ex_src1_o); end
    step; mid;
    n_vec++; if ({out_valid, out_res, out_rd} !== {1'b1, 64'h66, 5'd9}) begin n_err++;
      $display("FAIL b2b_out got v=%b res=%h rd=%0d want 1/66/9", out_valid, out_res, out_rd); end
    step;
  endtask

  task automatic test_flush;
    step; drive_op(64'h500, 64'd1, 64'd0, 5'd2, 1, 0, 0, 0);
    step; in_valid = 0;
    step;
    step; flush_i = 1; mdu_done_i = 1; mdu_res_i = 64'hBEEF; mid;
    n_vec++; if ({mdu_kill_o, in_ready} !== 2'b10) begin n_err++;
      $display("FAIL flush_kill got kill=%b rdy=%b want 1/0", mdu_kill_o, in_ready); end
    step; flush_i = 0; mdu_done_i = 0; mid;
    n_vec++; if ({mdu_kill_o, out_valid, mdu_req_o, in_ready} !== 4'b0001) begin n_err++;
      $display("FAIL flush_idle got kill=%b v=%b req=%b rdy=%b want 0/0/0/1", mdu_kill_o, out_valid, mdu_req_o, in_ready); end
    drive_op(64'h600, 64'd0, 64'h40, 5'd1, 0, 0, 1, 0);
    step; in_valid = 0; flush_i = 1;
    step; flush_i = 0; mid;
    n_vec++; if ({redirect_valid_o, out_valid, in_ready} !== 3'b001) begin n_err++;
      $display("FAIL flush_exec got redir=%b v=%b rdy=%b want 0/0/1", redirect_valid_o, out_valid, in_ready); end
  endtask

  task automatic test_reset_mid;
    out_ready = 0;
    step; drive_op(64'h700, 64'h3, 64'h4, 5'd9, 0, 0, 0, 0);
    step; in_valid = 0; alu_res_i = 64'h33;
    step; rst_n = 0; mid;
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL pre_reset_out got %b want 1", out_valid); end
    step; rst_n = 1; out_ready = 1; mid;
    n_vec++; if ({out_valid, out_res, out_rd, out_wen, ex_pc_o, ex_imm_o} !== '0) begin n_err++;
      $display("FAIL reset_out got v=%b res=%h rd=%0d wen=%b pc=%h", out_valid, out_res, out_rd, out_wen, ex_pc_o); end
    drive_op(64'h800, 64'h3, 64'h0, 5'd1, 1, 0, 0, 0);
    step; in_valid = 0;
    step; rst_n = 0; flush_i = 1; mid;
    n_vec++; if (mdu_kill_o !== 1'b0) begin n_err++; $display("FAIL reset_no_kill got %b want 0", mdu_kill_o); end
    step; flush_i = 0;
  endtask

  task automatic test_wrap;
    rst_n = 0;
    step; rst_n = 1; drive_op(64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 64'd8, 5'd1, 0, 0, 1, 0); mid;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL first_accept got %b want 1", in_ready); end
    step; in_valid = 0;
    step; mid;
    n_vec++; if ({redirect_valid_o, redirect_pc_o} !== {1'b1, 64'h4}) begin n_err++;
      $display("FAIL jal_wrap got v=%b pc=%h want 1/4", redirect_valid_o, redirect_pc_o); end
    step;
  endtask

  initial begin
    test_reset;
    test_alu;
    test_mdu;
    test_redirect;
    test_back_to_back;
    test_flush;
    test_reset_mid;
    test_wrap;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
